apb_slave_mem_responder: RTL and testbench

//  APB completer (slave) RTL: byte-addressed memory answering APB master transfers.
//  - Programmable wait states; PSTRB byte-lane writes; PSLVERR on out-of-range access.
//  - Sits behind one PSELx bit of the interconnect; DUT-side counterpart of the slave agent.

---
 rtl/apb_global_pkg.sv | 43 ++++
 rtl/apb_slave_byte_mem.sv | 56 +++++
 rtl/apb_slave_mem_responder.sv | 239 +++++++++++++++++++++++
 tb/tb_apb_slave_mem_responder.sv | 277 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/apb_global_pkg.sv
// ---------------------------------------------------------------------------
// apb_global_pkg
// Shared APB types and sizing constants for the APB completer memory slice.
// Holds the FSM state encoding, transfer direction, slave error response and
// protection encodings, plus the default bus/memory widths and the byte depth
// of the slave memory (MEM_DEPTH).
// ---------------------------------------------------------------------------
package apb_global_pkg;

  localparam int DATA_WIDTH        = 32;
  localparam int ADDRESS_WIDTH     = 32;
  localparam int MEMORY_WIDTH      = 8;
  localparam int SLAVE_MEMORY_SIZE = 12;
  localparam int MEM_DEPTH         = SLAVE_MEMORY_SIZE * 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2
  } apb_fsm_state_e;

  typedef enum logic {
    READ  = 1'b0,
    WRITE = 1'b1
  } tx_type_e;

  typedef enum logic {
    SLV_OKAY  = 1'b0,
    SLV_ERROR = 1'b1
  } slave_error_e;

  typedef enum logic [2:0] {
    NORMAL_SECURE_DATA              = 3'b000,
    PRIVILEGED_SECURE_DATA          = 3'b001,
    NORMAL_NONSECURE_DATA           = 3'b010,
    PRIVILEGED_NONSECURE_DATA       = 3'b011,
    NORMAL_SECURE_INSTRUCTION       = 3'b100,
    PRIVILEGED_SECURE_INSTRUCTION   = 3'b101,
    NORMAL_NONSECURE_INSTRUCTION    = 3'b110,
    PRIVILEGED_NONSECURE_INSTRUCTION = 3'b111
  } protection_type_e;

endpackage

// File: rtl/apb_slave_byte_mem.sv
// ---------------------------------------------------------------------------
// apb_slave_byte_mem
// Byte-addressed RAM with LANES byte-wide write lanes and LANES byte-wide
// asynchronous read lanes. Lane k touches location addr+k, so any start
// address (aligned or not) is accessed at byte granularity. Contents are
// never reset.
// Ports:
//   clk     in   write clock (rising edge)
//   we      in   write enable for the whole word
//   waddr   in   byte index of lane 0 for writes
//   wstrb   in   per-lane write enables
//   wdata   in   write data, lane k in wdata[MEM_W*k +: MEM_W]
//   raddr   in   byte index of lane 0 for reads
//   rdata   out  read data, lane k from location raddr+k
// ---------------------------------------------------------------------------
module apb_slave_byte_mem #(
  parameter int DEPTH = 12288,
  parameter int LANES = 4,
  parameter int MEM_W = 8,
  parameter int IDX_W = 14
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [IDX_W-1:0]         waddr,
  input  logic [LANES-1:0]         wstrb,
  input  logic [LANES*MEM_W-1:0]   wdata,
  input  logic [IDX_W-1:0]         raddr,
  output logic [LANES*MEM_W-1:0]   rdata
);

  logic [MEM_W-1:0] mem [DEPTH];

  // Strobed write: each enabled lane lands on its own byte; a lane whose
  // location would fall beyond the array is dropped rather than wrapping.
  always_ff @(posedge clk) begin
    if (we) begin
      for (int k = 0; k < LANES; k++) begin
        if (wstrb[k] && (({1'b0, waddr} + (IDX_W+1)'(k)) < (IDX_W+1)'(DEPTH))) begin
          mem[waddr + IDX_W'(k)] <= wdata[MEM_W*k +: MEM_W];
        end
      end
    end
  end

  // Combinational read of LANES consecutive bytes, little-endian; lanes past
  // the end of the array read as zero.
  always_comb begin
    rdata = '0;
    for (int k = 0; k < LANES; k++) begin
      if (({1'b0, raddr} + (IDX_W+1)'(k)) < (IDX_W+1)'(DEPTH)) begin
        rdata[MEM_W*k +: MEM_W] = mem[raddr + IDX_W'(k)];
      end
    end
  end

endmodule

// File: rtl/apb_slave_mem_responder.sv
// ---------------------------------------------------------------------------
// apb_slave_mem_responder
// APB completer answering transfers from a byte-addressed memory. Inserts a
// programmable number of wait states, honours PSTRB on writes, flags
// out-of-range accesses with PSLVERR and pulses proto_err on bus protocol
// violations.
// Ports:
//   pclk         in   APB clock
//   preset       in   asynchronous active-high reset
//   psel         in   this slave's select
//   penable      in   access phase
//   pwrite       in   1 = write, 0 = read
//   paddr        in   byte address
//   pwdata       in   write data, little-endian byte lanes
//   pstrb        in   write byte enables
//   pprot        in   protection type (not used for decode)
//   wait_states  in   wait cycles per transfer, sampled in SETUP
//   pready       out  transfer complete
//   prdata       out  read data, valid with pready on reads
//   pslverr      out  error response, valid with pready
//   proto_err    out  one-cycle pulse on a protocol violation
// ---------------------------------------------------------------------------
module apb_slave_mem_responder #(
  parameter int                       ADDRESS_WIDTH     = apb_global_pkg::ADDRESS_WIDTH,
  parameter int                       DATA_WIDTH        = apb_global_pkg::DATA_WIDTH,
  parameter int                       MEMORY_WIDTH      = apb_global_pkg::MEMORY_WIDTH,
  parameter int                       SLAVE_MEMORY_SIZE = apb_global_pkg::SLAVE_MEMORY_SIZE,
  parameter logic [ADDRESS_WIDTH-1:0] MIN_ADDRESS       = '0,
  parameter int                       WAIT_W            = 4
) (
  input  logic                      pclk,
  input  logic                      preset,
  input  logic                      psel,
  input  logic                      penable,
  input  logic                      pwrite,
  input  logic [ADDRESS_WIDTH-1:0]  paddr,
  input  logic [DATA_WIDTH-1:0]     pwdata,
  input  logic [DATA_WIDTH/8-1:0]   pstrb,
  input  logic [2:0]                pprot,
  input  logic [WAIT_W-1:0]         wait_states,
  output logic                      pready,
  output logic [DATA_WIDTH-1:0]     prdata,
  output logic                      pslverr,
  output logic                      proto_err
);

  import apb_global_pkg::*;

  localparam int LANES = DATA_WIDTH / MEMORY_WIDTH;
  localparam int DEPTH = SLAVE_MEMORY_SIZE * 1024;
  localparam int IDX_W = $clog2(DEPTH);
  localparam int XW    = ADDRESS_WIDTH + 1;

  apb_fsm_state_e          state_q, state_d;
  logic [WAIT_W-1:0]       cnt_q, cnt_d;
  logic [IDX_W-1:0]        addr_q, addr_d;
  tx_type_e                write_q, write_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [LANES-1:0]        strb_q, strb_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    proto_err_q, proto_err_d;
  logic                    first_q, first_d;
  logic                    done_q, done_d;

  logic [XW-1:0]           offset;
  logic [XW-1:0]           endAddr;
  logic                    belowBase;
  logic                    curErr;
  logic [IDX_W-1:0]        curIdx;
  logic [IDX_W-1:0]        rdIdx;
  logic [DATA_WIDTH-1:0]   memRdata;
  logic                    memWe;
  logic                    unused_pprot;

  assign unused_pprot = ^pprot;

  // Range decode on the live address, done one bit wider than the bus so
  // that neither the subtraction below MIN_ADDRESS nor the end-of-word
  // addition can wrap into a false in-range result.
  assign belowBase = (paddr < MIN_ADDRESS);
  assign offset    = {1'b0, paddr} - {1'b0, MIN_ADDRESS};
  assign endAddr   = offset + XW'(LANES);
  assign curErr    = belowBase | (endAddr > XW'(DEPTH));
  assign curIdx    = offset[IDX_W-1:0];

  // A zero-wait read registers its data while still in SETUP, before the
  // address has been latched, so the read port looks at the live address
  // in that state and at the latched one otherwise.
  assign rdIdx = (state_q == SETUP) ? curIdx : addr_q;

  apb_slave_byte_mem #(
    .DEPTH (DEPTH),
    .LANES (LANES),
    .MEM_W (MEMORY_WIDTH),
    .IDX_W (IDX_W)
  ) u_mem (
    .clk   (pclk),
    .we    (memWe),
    .waddr (addr_q),
    .wstrb (strb_q),
    .wdata (wdata_q),
    .raddr (rdIdx),
    .rdata (memRdata)
  );

  // State and datapath registers. Reset returns every output to zero at
  // once; memory is left alone, and since the write enable is decoded from
  // the state, an in-flight transfer is dropped without touching memory.
  always_ff @(posedge pclk or posedge preset) begin
    if (preset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      addr_q      <= '0;
      write_q     <= READ;
      err_q       <= 1'b0;
      wdata_q     <= '0;
      strb_q      <= '0;
      pready_q    <= 1'b0;
      pslverr_q   <= 1'b0;
      prdata_q    <= '0;
      proto_err_q <= 1'b0;
      first_q     <= 1'b0;
      done_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      addr_q      <= addr_d;
      write_q     <= write_d;
      err_q       <= err_d;
      wdata_q     <= wdata_d;
      strb_q      <= strb_d;
      pready_q    <= pready_d;
      pslverr_q   <= pslverr_d;
      prdata_q    <= prdata_d;
      proto_err_q <= proto_err_d;
      first_q     <= first_d;
      done_q      <= done_d;
    end
  end

  // Next-state and response logic. pready/pslverr/prdata are registered, so
  // they are computed one cycle ahead: in SETUP for a zero-wait transfer,
  // otherwise in the ACCESS cycle where the counter steps from 1 to 0.
  // After a completion the FSM spends one cycle in ACCESS with done_q set;
  // that cycle looks at the bus to decide between a back-to-back SETUP and
  // IDLE.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    write_d     = write_q;
    err_d       = err_q;
    wdata_d     = wdata_q;
    strb_d      = strb_q;
    pready_d    = 1'b0;
    pslverr_d   = 1'b0;
    prdata_d    = '0;
    proto_err_d = 1'b0;
    first_d     = 1'b0;
    done_d      = 1'b0;
    memWe       = 1'b0;

    case (state_q)
      IDLE: begin
        if (psel && !penable) begin
          state_d = SETUP;
        end else if (psel && penable) begin
          proto_err_d = 1'b1;
        end
      end

      SETUP: begin
        addr_d  = curIdx;
        write_d = tx_type_e'(pwrite);
        err_d   = curErr;
        wdata_d = pwdata;
        strb_d  = pstrb;
        cnt_d   = wait_states;
        first_d = 1'b1;
        state_d = ACCESS;
        if (wait_states == '0) begin
          pready_d  = 1'b1;
          pslverr_d = curErr;
          prdata_d  = (!pwrite && !curErr) ? memRdata : '0;
        end
      end

      ACCESS: begin
        if (done_q) begin
          if (psel && !penable) begin
            state_d = SETUP;
          end else begin
            state_d = IDLE;
            if (psel && penable) begin
              proto_err_d = 1'b1;
            end
          end
        end else if (!psel) begin
          state_d     = IDLE;
          proto_err_d = 1'b1;
        end else begin
          if (first_q && !penable) begin
            proto_err_d = 1'b1;
          end
          if (pready_q) begin
            if (penable) begin
              memWe  = (write_q == WRITE) && !err_q;
              done_d = 1'b1;
            end else begin
              pready_d  = 1'b1;
              pslverr_d = pslverr_q;
              prdata_d  = prdata_q;
            end
          end else if (cnt_q != '0) begin
            cnt_d = cnt_q - WAIT_W'(1);
            if (cnt_q == WAIT_W'(1)) begin
              pready_d  = 1'b1;
              pslverr_d = err_q;
              prdata_d  = ((write_q == READ) && !err_q) ? memRdata : '0;
            end
          end
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign pready    = pready_q;
  assign pslverr   = pslverr_q;
  assign prdata    = prdata_q;
  assign proto_err = proto_err_q;

endmodule

// File: tb/tb_apb_slave_mem_responder.sv
// ---------------------------------------------------------------------------
// tb_apb_slave_mem_responder
// Directed bench for the APB memory completer: an APB master driven from
// one initial block, a byte-level reference memory, and a queue of expected
// responses that is drained as the DUT completes each transfer.
// ---------------------------------------------------------------------------
module tb_apb_slave_mem_responder;

  localparam int DEPTH = apb_global_pkg::MEM_DEPTH;

  logic        pclk;
  logic        preset;
  logic        psel;
  logic        penable;
  logic        pwrite;
  logic [31:0] paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [2:0]  pprot;
  logic [3:0]  wait_states;
  logic        pready;
  logic [31:0] prdata;
  logic        pslverr;
  logic        proto_err;

  typedef struct {
    string       tag;
    logic        isRead;
    logic        err;
    logic [31:0] data;
  } expEntry_t;

  expEntry_t   sb[$];
  logic [7:0]  model [int];
  int          nChecks = 0;
  int          nFail   = 0;

  apb_slave_mem_responder dut (
    .pclk        (pclk),
    .preset      (preset),
    .psel        (psel),
    .penable     (penable),
    .pwrite      (pwrite),
    .paddr       (paddr),
    .pwdata      (pwdata),
    .pstrb       (pstrb),
    .pprot       (pprot),
    .wait_states (wait_states),
    .pready      (pready),
    .prdata      (prdata),
    .pslverr     (pslverr),
    .proto_err   (proto_err)
  );

  // 10 ns APB clock.
  initial pclk = 1'b0;
  always #5 pclk = ~pclk;

  // One comparison: counted, and reported with tag/observed/expected on a miss.
  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    nChecks++;
    assert (observed === expected) else begin
      nFail++;
      $error("[TB] FAIL %s: observed %h, expected %h", tag, observed, expected);
    end
  endtask

  // Reference memory: plain byte array updated lane by lane.
  task automatic modelWrite(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] strb);
    for (int k = 0; k < 4; k++) begin
      if (strb[k]) model[int'(addr) + k] = data[8*k +: 8];
    end
  endtask

  function automatic logic [31:0] modelRead(input logic [31:0] addr);
    logic [31:0] r;
    for (int k = 0; k < 4; k++) begin
      r[8*k +: 8] = model.exists(int'(addr) + k) ? model[int'(addr) + k] : 8'hxx;
    end
    return r;
  endfunction

  // One APB transfer, starting at posedge+1 with the bus setup phase.
  // The expected response goes into the scoreboard before the bus is driven
  // and is popped when pready is seen. Low-pready cycles after penable rises
  // are counted: the completer's SETUP cycle plus one per wait state.
  task automatic applyStimulus(input string tag, input logic isWrite, input logic [31:0] addr,
                               input logic [31:0] data, input logic [3:0] strb, input int waits);
    expEntry_t   e;
    expEntry_t   popped;
    int          lowCycles;
    logic        got;
    logic [31:0] rdSeen;
    logic        errSeen;
    e.tag    = tag;
    e.isRead = !isWrite;
    e.err    = (longint'(addr) + 4 > longint'(DEPTH));
    e.data   = '0;
    if (!e.err) begin
      if (isWrite) modelWrite(addr, data, strb);
      else         e.data = modelRead(addr);
    end
    sb.push_back(e);

    psel        = 1'b1;
    penable     = 1'b0;
    pwrite      = isWrite;
    paddr       = addr;
    pwdata      = data;
    pstrb       = strb;
    wait_states = 4'(waits);
    @(posedge pclk); #1;
    penable = 1'b1;

    lowCycles = 0;
    got       = 1'b0;
    rdSeen    = '0;
    errSeen   = 1'b0;
    while (!got && lowCycles < 40) begin
      @(negedge pclk);
      if (pready === 1'b1) begin
        got     = 1'b1;
        rdSeen  = prdata;
        errSeen = pslverr;
      end else begin
        lowCycles++;
      end
    end
    nChecks++;
    assert (got) else begin
      nFail++;
      $error("[TB] FAIL %s_timeout: observed no pready, expected pready within 40 cycles", tag);
    end
    if (got) checkOutput({tag, "_lat"}, 32'(lowCycles), 32'(waits + 1));

    if (sb.size() > 0) begin
      popped = sb.pop_front();
      if (got) begin
        checkOutput({popped.tag, "_err"}, {31'b0, errSeen}, {31'b0, popped.err});
        if (popped.isRead || popped.err) checkOutput({popped.tag, "_rdata"}, rdSeen, popped.data);
      end
    end

    @(posedge pclk); #1;
    psel    = 1'b0;
    penable = 1'b0;
  endtask

  task automatic idleCycle();
    @(posedge pclk); #1;
  endtask

  // After a completion the response outputs must all be back at zero.
  task automatic checkIdleOutputs(input string tag);
    @(negedge pclk);
    checkOutput({tag, "_pready0"},  {31'b0, pready},  32'h0);
    checkOutput({tag, "_pslverr0"}, {31'b0, pslverr}, 32'h0);
    checkOutput({tag, "_prdata0"},  prdata,           32'h0);
  endtask

  initial begin
    preset      = 1'b1;
    psel        = 1'b0;
    penable     = 1'b0;
    pwrite      = 1'b0;
    paddr       = '0;
    pwdata      = '0;
    pstrb       = '0;
    pprot       = 3'b000;
    wait_states = '0;

    // Reset state.
    repeat (2) @(negedge pclk);
    checkOutput("reset_pready",    {31'b0, pready},    32'h0);
    checkOutput("reset_pslverr",   {31'b0, pslverr},   32'h0);
    checkOutput("reset_prdata",    prdata,             32'h0);
    checkOutput("reset_proto_err", {31'b0, proto_err}, 32'h0);
    @(posedge pclk); #1;
    preset = 1'b0;
    idleCycle();

    // 1: zero-wait write then read.
    applyStimulus("t1_wr", 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, 0);
    checkIdleOutputs("t1_wr_after");
    idleCycle();
    applyStimulus("t1_rd", 1'b0, 32'h10, 32'h0, 4'h0, 0);
    idleCycle();

    // 2: three wait states on a read.
    applyStimulus("t2_rd", 1'b0, 32'h10, 32'h0, 4'h0, 3);
    idleCycle();

    // 3: partial strobe write over a known word.
    applyStimulus("t3_wr_full", 1'b1, 32'h20, 32'h11223344, 4'hF, 0);
    idleCycle();
    applyStimulus("t3_wr_strb", 1'b1, 32'h20, 32'hAABBCCDD, 4'b0101, 2);
    idleCycle();
    applyStimulus("t3_rd", 1'b0, 32'h20, 32'h0, 4'h0, 0);
    idleCycle();

    // Unaligned write straddling two words, read back aligned.
    applyStimulus("ua_clr0", 1'b1, 32'h40, 32'h0, 4'hF, 0);
    applyStimulus("ua_clr1", 1'b1, 32'h44, 32'h0, 4'hF, 0);
    applyStimulus("ua_wr",   1'b1, 32'h41, 32'hCAFEF00D, 4'hF, 1);
    applyStimulus("ua_rd0",  1'b0, 32'h40, 32'h0, 4'h0, 0);
    applyStimulus("ua_rd1",  1'b0, 32'h44, 32'h0, 4'h0, 0);
    idleCycle();

    // 4: last in-range word, then a write straddling the end of memory.
    applyStimulus("t4_pre", 1'b1, 32'(DEPTH - 4), 32'h01020304, 4'hF, 0);
    idleCycle();
    applyStimulus("t4_wr_oob", 1'b1, 32'(DEPTH - 2), 32'hFFFFFFFF, 4'hF, 1);
    checkIdleOutputs("t4_after");
    idleCycle();
    applyStimulus("t4_rd_oob", 1'b0, 32'(DEPTH - 2), 32'h0, 4'h0, 0);
    idleCycle();
    applyStimulus("t4_rd", 1'b0, 32'(DEPTH - 4), 32'h0, 4'h0, 0);
    idleCycle();

    // 5: back-to-back write/read/write with no idle cycle between them.
    applyStimulus("t5_wr0", 1'b1, 32'h50, 32'h5A5AA5A5, 4'hF, 0);
    applyStimulus("t5_rd0", 1'b0, 32'h50, 32'h0, 4'h0, 1);
    applyStimulus("t5_wr1", 1'b1, 32'h54, 32'h87654321, 4'hF, 2);
    applyStimulus("t5_rd1", 1'b0, 32'h54, 32'h0, 4'h0, 0);
    idleCycle();

    // 6: reset during the second ACCESS cycle of a five-wait write.
    applyStimulus("t6_pre", 1'b1, 32'h30, 32'h55667788, 4'hF, 0);
    idleCycle();
    psel        = 1'b1;
    penable     = 1'b0;
    pwrite      = 1'b1;
    paddr       = 32'h30;
    pwdata      = 32'h99999999;
    pstrb       = 4'hF;
    wait_states = 4'd5;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(posedge pclk); #1;
    @(posedge pclk); #1;
    preset = 1'b1;
    #1;
    checkOutput("t6_rst_pready",    {31'b0, pready},    32'h0);
    checkOutput("t6_rst_pslverr",   {31'b0, pslverr},   32'h0);
    checkOutput("t6_rst_prdata",    prdata,             32'h0);
    checkOutput("t6_rst_proto_err", {31'b0, proto_err}, 32'h0);
    psel    = 1'b0;
    penable = 1'b0;
    @(posedge pclk); #1;
    preset = 1'b0;
    idleCycle();
    applyStimulus("t6_rd", 1'b0, 32'h30, 32'h0, 4'h0, 0);
    idleCycle();

    // 7: psel and penable together straight out of IDLE.
    psel    = 1'b1;
    penable = 1'b1;
    @(negedge pclk);
    checkOutput("t7_proto_before", {31'b0, proto_err}, 32'h0);
    @(posedge pclk); #1;
    psel    = 1'b0;
    penable = 1'b0;
    @(negedge pclk);
    checkOutput("t7_proto_pulse", {31'b0, proto_err}, 32'h1);
    checkOutput("t7_pready",      {31'b0, pready},    32'h0);
    @(negedge pclk);
    checkOutput("t7_proto_clear", {31'b0, proto_err}, 32'h0);
    checkOutput("t7_pready_after", {31'b0, pready},   32'h0);

    // Every expected response must have been consumed.
    checkOutput("sb_empty", 32'(sb.size()), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFail);
    $finish;
  end

endmodule
